mmio_console: RTL and testbench

MMIO_CONSOLE -- requirements
Module: mmio_console

---
 rtl/mmio_console.sv | 130 +++++++++++++
 tb/tb_mmio_console.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_console.sv
// Memory-mapped console: CPU stores to PRINT_ADDR queue words for a host sink, a DONE_ADDR store ends the program.
// Latency: a printed word appears on out_data one cycle after its store; no same-cycle bypass.
// Backpressure: out_valid/out_ready handshake; prints into a full FIFO are dropped and flagged as overflow.
module mmio_console #(
    parameter logic [31:0] PRINT_ADDR  = 32'h0001_0000,
    parameter logic [31:0] DONE_ADDR   = 32'h0001_0004,
    parameter logic [31:0] STATUS_ADDR = 32'h0001_0008,
    parameter int          DEPTH       = 4
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic [31:0] memory_address,
    input  logic        memory_write_enable,
    input  logic [31:0] memory_write_data,
    output logic [31:0] memory_read_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        done,
    output logic [31:0] exit_code
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t          state;
    logic [31:0]     mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            overflow;
    logic            full;
    logic            empty;
    logic            print_store;
    logic            done_store;
    logic            push;
    logic            pop;
    logic [3:0]      count_field;

    assign full        = (count == CW'(DEPTH));
    assign empty       = (count == '0);
    // Stores only take effect while the program is still running.
    assign print_store = memory_write_enable && (memory_address == PRINT_ADDR) && (state == ST_RUN);
    assign done_store  = memory_write_enable && (memory_address == DONE_ADDR) && (state == ST_RUN);
    assign out_valid   = !empty;
    assign out_data    = mem[rd_ptr];
    assign pop         = out_valid && out_ready;
    // A full FIFO still accepts a word when the head leaves in the same cycle.
    assign push        = print_store && (!full || pop);
    assign count_field = 4'(count);

    assign memory_read_data = (memory_address == STATUS_ADDR)
                            ? {24'b0, count_field, done, overflow, empty, full}
                            : 32'b0;

    // FIFO storage is not reset; only the pointers and count define its contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= memory_write_data;
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
            if (print_store && full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

    // Program lifecycle: run, drain remaining prints, then report done with the captured exit code.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= ST_RUN;
            done      <= 1'b0;
            exit_code <= 32'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (done_store) begin
                        exit_code <= memory_write_data;
                        if (empty && !push) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (empty) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    done <= 1'b1;
                end
                default: begin
                    state <= ST_RUN;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_console.sv
// Directed self-checking bench for mmio_console.
// All stimulus changes and output sampling happen at the falling clock edge.
// Each task starts and ends at a falling edge.
module tb_mmio_console;

    localparam logic [31:0] PRINT_ADDR  = 32'h0001_0000;
    localparam logic [31:0] DONE_ADDR   = 32'h0001_0004;
    localparam logic [31:0] STATUS_ADDR = 32'h0001_0008;

    logic        clk;
    logic        n_rst;
    logic [31:0] memory_address;
    logic        memory_write_enable;
    logic [31:0] memory_write_data;
    logic [31:0] memory_read_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        done;
    logic [31:0] exit_code;

    int checks;
    int failures;

    mmio_console #(
        .PRINT_ADDR (PRINT_ADDR),
        .DONE_ADDR  (DONE_ADDR),
        .STATUS_ADDR(STATUS_ADDR),
        .DEPTH      (4)
    ) dut (
        .clk                (clk),
        .n_rst              (n_rst),
        .memory_address     (memory_address),
        .memory_write_enable(memory_write_enable),
        .memory_write_data  (memory_write_data),
        .memory_read_data   (memory_read_data),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .out_data           (out_data),
        .done               (done),
        .exit_code          (exit_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One store, presented for exactly one rising edge.
    task automatic store(input logic [31:0] a, input logic [31:0] d);
        memory_address      = a;
        memory_write_data   = d;
        memory_write_enable = 1'b1;
        @(negedge clk);
        memory_write_enable = 1'b0;
        memory_address      = 32'h0;
    endtask

    task automatic read_status(output logic [31:0] v);
        memory_address = STATUS_ADDR;
        #1;
        v = memory_read_data;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        n_rst = 1'b0;
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [31:0] st;
        n_rst = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || done !== 1'b0 || exit_code !== 32'h0) begin
            failures++;
            $display("FAIL reset_outputs: valid=%b done=%b exit=%h required 0 0 0", out_valid, done, exit_code);
        end
        read_status(st);
        checks++;
        if (st !== 32'h2) begin
            failures++;
            $display("FAIL reset_status: got %h required %h", st, 32'h2);
        end
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_in_order();
        logic [31:0] exp;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp = 32'd5 + 32'(i);
            store(PRINT_ADDR, exp);
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp) begin
                failures++;
                $display("FAIL in_order_%0d: valid=%b data=%h required 1 %h", i, out_valid, out_data, exp);
            end
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL in_order_drained: valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_other_addr();
        logic [31:0] st;
        out_ready = 1'b0;
        store(32'h0001_000C, 32'h11);
        store(STATUS_ADDR, 32'hFF);
        store(32'h0000_0000, 32'h22);
        read_status(st);
        checks++;
        if (out_valid !== 1'b0 || st !== 32'h2 || done !== 1'b0) begin
            failures++;
            $display("FAIL other_addr: valid=%b status=%h done=%b required 0 00000002 0", out_valid, st, done);
        end
        memory_address = 32'h0001_000C;
        #1;
        checks++;
        if (memory_read_data !== 32'h0) begin
            failures++;
            $display("FAIL read_other_addr: got %h required 0", memory_read_data);
        end
        @(negedge clk);
    endtask

    task automatic test_overflow();
        logic [31:0] st;
        logic [31:0] exp;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) store(PRINT_ADDR, 32'hA + 32'(i));
        read_status(st);
        checks++;
        if (st !== 32'h45) begin
            failures++;
            $display("FAIL overflow_status: got %h required %h", st, 32'h45);
        end
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            exp = 32'hA + 32'(i);
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp) begin
                failures++;
                $display("FAIL overflow_pop_%0d: valid=%b data=%h required 1 %h", i, out_valid, out_data, exp);
            end
            out_ready = 1'b1;
            @(negedge clk);
        end
        read_status(st);
        checks++;
        if (out_valid !== 1'b0 || st !== 32'h6) begin
            failures++;
            $display("FAIL overflow_after: valid=%b status=%h required 0 00000006", out_valid, st);
        end
        @(negedge clk);
    endtask

    task automatic test_done_drain();
        logic [31:0] st;
        out_ready = 1'b0;
        store(PRINT_ADDR, 32'h1);
        store(PRINT_ADDR, 32'h2);
        store(DONE_ADDR, 32'h2A);
        read_status(st);
        checks++;
        if (done !== 1'b0 || exit_code !== 32'h2A || st !== 32'h20) begin
            failures++;
            $display("FAIL drain_start: done=%b exit=%h status=%h required 0 2a 20", done, exit_code, st);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        read_status(st);
        checks++;
        if (done !== 1'b0 || st !== 32'h2) begin
            failures++;
            $display("FAIL drain_empty: done=%b status=%h required 0 00000002", done, st);
        end
        @(negedge clk);
        read_status(st);
        checks++;
        if (done !== 1'b1 || exit_code !== 32'h2A || st !== 32'hA) begin
            failures++;
            $display("FAIL drain_done: done=%b exit=%h status=%h required 1 2a 0a", done, exit_code, st);
        end
        @(negedge clk);
    endtask

    task automatic test_done_ignore();
        logic [31:0] st;
        out_ready = 1'b0;
        store(PRINT_ADDR, 32'h55);
        store(DONE_ADDR, 32'h99);
        read_status(st);
        checks++;
        if (out_valid !== 1'b0 || exit_code !== 32'h2A || done !== 1'b1 || st !== 32'hA) begin
            failures++;
            $display("FAIL done_ignore: valid=%b exit=%h done=%b status=%h required 0 2a 1 0a",
                     out_valid, exit_code, done, st);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [31:0] st;
        logic [31:0] exp;
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) store(PRINT_ADDR, 32'(i));
        read_status(st);
        checks++;
        if (st !== 32'h41) begin
            failures++;
            $display("FAIL b2b_full: status=%h required 41", st);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            store(PRINT_ADDR, 32'd5 + 32'(i));
            exp = 32'd2 + 32'(i);
            read_status(st);
            checks++;
            if (st !== 32'h41 || out_data !== exp) begin
                failures++;
                $display("FAIL b2b_step_%0d: status=%h data=%h required 41 %h", i, st, out_data, exp);
            end
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            exp = 32'd6 + 32'(i);
            if (i < 3) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== exp) begin
                    failures++;
                    $display("FAIL b2b_drain_%0d: valid=%b data=%h required 1 %h", i, out_valid, out_data, exp);
                end
            end
        end
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_end: valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_reset_mid_drain();
        logic [31:0] st;
        out_ready = 1'b0;
        store(PRINT_ADDR, 32'h31);
        store(PRINT_ADDR, 32'h32);
        store(PRINT_ADDR, 32'h33);
        store(DONE_ADDR, 32'h7);
        checks++;
        if (out_valid !== 1'b1 || exit_code !== 32'h7) begin
            failures++;
            $display("FAIL mid_drain_pre: valid=%b exit=%h required 1 7", out_valid, exit_code);
        end
        #2;
        n_rst = 1'b0;
        read_status(st);
        checks++;
        if (out_valid !== 1'b0 || done !== 1'b0 || st !== 32'h2 || exit_code !== 32'h0) begin
            failures++;
            $display("FAIL mid_drain_reset: valid=%b done=%b status=%h exit=%h required 0 0 2 0",
                     out_valid, done, st, exit_code);
        end
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        store(PRINT_ADDR, 32'h77);
        read_status(st);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h77 || st !== 32'h10) begin
            failures++;
            $display("FAIL post_reset_print: valid=%b data=%h status=%h required 1 77 10", out_valid, out_data, st);
        end
        @(negedge clk);
    endtask

    initial begin
        checks              = 0;
        failures            = 0;
        n_rst               = 1'b0;
        memory_address      = 32'h0;
        memory_write_enable = 1'b0;
        memory_write_data   = 32'h0;
        out_ready           = 1'b0;
        @(negedge clk);
        test_reset();
        test_in_order();
        test_other_addr();
        test_overflow();
        apply_reset();
        test_done_drain();
        test_done_ignore();
        apply_reset();
        test_back_to_back();
        apply_reset();
        test_reset_mid_drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
